// File: rtl/hdmi_ts_pkg.sv
// Shared definitions for the video-over-UDP line writer: datain field positions,
// packet geometry and FSM encoding.
package hdmi_ts_pkg;

  localparam int DW_HALF = 27;
  localparam int DW_Y_HI = 26;
  localparam int DW_Y_LO = 16;

  localparam int PIX_PER_PKT_DEF = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CLOSE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; updates 1 cycle after inc, holds at all-ones.
// No backpressure: inc is a single-cycle strobe that is never refused.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gmii_line_writer.sv
// Writes received pixel words into a ping-pong line RAM, 1-cycle write latency, and
// flags complete lines; no backpressure: the receiver stream is accepted unconditionally.
module gmii_line_writer
  import hdmi_ts_pkg::*;
#(
  parameter int PIX_PER_PKT = PIX_PER_PKT_DEF,
  parameter int LINE_W      = 11,
  parameter int ERR_W       = 16
) (
  input  logic              clk125,
  input  logic              sys_rst,
  input  logic [28:0]       datain,
  input  logic              recv_en,
  input  logic              packet_en,
  output logic              ram_we,
  output logic [11:0]       ram_addr,
  output logic [15:0]       ram_din,
  output logic              line_done,
  output logic [LINE_W-1:0] line_num,
  output logic [ERR_W-1:0]  short_cnt,
  output logic [ERR_W-1:0]  drop_cnt
);

  localparam logic [9:0] PIX_MAX = 10'(PIX_PER_PKT);

  wr_state_t         state_q, state_d;
  logic [9:0]        pix_q, pix_d;
  logic              half_q, half_d;
  logic [LINE_W-1:0] cur_y_q, cur_y_d;
  logic [LINE_W-1:0] trk_y_q, trk_y_d;
  logic [1:0]        half_ok_q, half_ok_d;
  logic              pkt_en_q;
  logic              rise_pend_q, rise_pend_d;
  logic              ram_we_q, ram_we_d;
  logic [11:0]       ram_addr_q, ram_addr_d;
  logic [15:0]       ram_din_q, ram_din_d;
  logic              line_done_q, line_done_d;
  logic [LINE_W-1:0] line_num_q, line_num_d;

  logic       pkt_rise, pkt_fall;
  logic       short_inc, drop_inc;
  logic [1:0] ok_base, ok_new;
  logic       unused_rsvd;

  assign pkt_rise    = packet_en & ~pkt_en_q;
  assign pkt_fall    = ~packet_en & pkt_en_q;
  assign unused_rsvd = datain[28];

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    half_d      = half_q;
    cur_y_d     = cur_y_q;
    trk_y_d     = trk_y_q;
    half_ok_d   = half_ok_q;
    rise_pend_d = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    line_done_d = 1'b0;
    line_num_d  = line_num_q;
    short_inc   = 1'b0;
    drop_inc    = 1'b0;
    ok_base     = half_ok_q;
    ok_new      = half_ok_q;

    case (state_q)
      ST_IDLE: begin
        if (pkt_rise || rise_pend_q) begin
          state_d = ST_RECV;
          pix_d   = '0;
        end
      end
      ST_RECV: begin
        if (recv_en) begin
          half_d  = datain[DW_HALF];
          cur_y_d = LINE_W'(datain[DW_Y_HI:DW_Y_LO]);
          if (pix_q < PIX_MAX) begin
            ram_we_d   = 1'b1;
            ram_addr_d = {datain[DW_Y_LO], datain[DW_HALF], pix_q};
            ram_din_d  = datain[15:0];
            pix_d      = pix_q + 10'd1;
          end
        end
        if (pkt_fall) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        state_d     = ST_IDLE;
        // An edge seen here would be lost by the delayed-copy detector in IDLE.
        rise_pend_d = pkt_rise;
        if ((cur_y_q != trk_y_q) && (half_ok_q != 2'b00)) begin
          drop_inc = 1'b1;
          ok_base  = 2'b00;
        end
        trk_y_d = cur_y_q;
        ok_new  = ok_base;
        if (pix_q == PIX_MAX) ok_new = ok_base | (2'b01 << half_q);
        else                  short_inc = 1'b1;
        if (ok_new == 2'b11) begin
          line_done_d = 1'b1;
          line_num_d  = cur_y_q;
          half_ok_d   = 2'b00;
        end else begin
          half_ok_d   = ok_new;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    // Tracks packet_en through reset so a packet already in flight is not seen as new.
    pkt_en_q <= packet_en;
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      pix_q       <= '0;
      half_q      <= 1'b0;
      cur_y_q     <= '0;
      trk_y_q     <= '0;
      half_ok_q   <= 2'b00;
      rise_pend_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      line_done_q <= 1'b0;
      line_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      half_q      <= half_d;
      cur_y_q     <= cur_y_d;
      trk_y_q     <= trk_y_d;
      half_ok_q   <= half_ok_d;
      rise_pend_q <= rise_pend_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      line_done_q <= line_done_d;
      line_num_q  <= line_num_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_short_cnt (
    .clk (clk125),
    .rst (sys_rst),
    .inc (short_inc),
    .cnt (short_cnt)
  );

  sat_counter #(.W(ERR_W)) u_drop_cnt (
    .clk (clk125),
    .rst (sys_rst),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign line_done = line_done_q;
  assign line_num  = line_num_q;

endmodule

// File: tb/tb_gmii_line_writer.sv
// Scoreboard bench for gmii_line_writer: expected RAM writes and line completions are
// queued as stimulus is driven and checked by monitors on the falling clock edge.
module tb_gmii_line_writer;

  logic        clk125 = 1'b0;
  logic        sys_rst;
  logic [28:0] datain;
  logic        recv_en;
  logic        packet_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic        line_done;
  logic [10:0] line_num;
  logic [15:0] short_cnt;
  logic [15:0] drop_cnt;

  always #4 clk125 = ~clk125;

  gmii_line_writer dut (
    .clk125    (clk125),
    .sys_rst   (sys_rst),
    .datain    (datain),
    .recv_en   (recv_en),
    .packet_en (packet_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .line_done (line_done),
    .line_num  (line_num),
    .short_cnt (short_cnt),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [11:0] addr;
    logic [15:0] dat;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [10:0] done_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;

  always @(posedge clk125) cyc <= cyc + 1;

  always @(negedge clk125) begin
    if (ram_we === 1'b1) begin
      n_vec++;
      if (wr_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_write addr=%h din=%h (no write expected)", ram_addr, ram_din);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (ram_addr !== e.addr || ram_din !== e.dat || cyc !== e.cyc + 1) begin
          n_miss++;
          $display("FAIL write addr=%h din=%h cyc=%0d, expected addr=%h din=%h cyc=%0d",
                   ram_addr, ram_din, cyc, e.addr, e.dat, e.cyc + 1);
        end
      end
    end
    if (line_done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_line_done line_num=%0d (no completion expected)", line_num);
      end else begin
        logic [10:0] ey;
        ey = done_q.pop_front();
        if (line_num !== ey) begin
          n_miss++;
          $display("FAIL line_num got %0d expected %0d", line_num, ey);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic drive_word(input logic [10:0] y, input logic h, input logic expect_wr,
                            input logic [9:0] pix);
    logic [15:0] w;
    wr_t         e;
    w       = 16'($urandom);
    datain  = {1'($urandom), h, y, w};
    recv_en = 1'b1;
    if (expect_wr) begin
      e.addr = {y[0], h, pix};
      e.dat  = w;
      e.cyc  = cyc;
      wr_q.push_back(e);
    end
    tick();
  endtask

  task automatic send_pkt(input logic [10:0] y, input logic h, input int n);
    packet_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < n; i++) drive_word(y, h, i < 640, 10'(i));
    recv_en   = 1'b0;
    packet_en = 1'b0;
    repeat (14) tick();
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_pending writes=%0d dones=%0d, expected 0 and 0",
               name, wr_q.size(), done_q.size());
    end
  endtask

  task automatic check_cnts(input string name, input logic [15:0] es, input logic [15:0] ed);
    n_vec++;
    if (short_cnt !== es || drop_cnt !== ed) begin
      n_miss++;
      $display("FAIL %s_counters short=%0d drop=%0d, expected short=%0d drop=%0d",
               name, short_cnt, drop_cnt, es, ed);
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    datain    = '0;
    recv_en   = 1'b0;
    packet_en = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    n_vec++;
    if (ram_we !== 1'b0 || ram_addr !== 12'h0 || ram_din !== 16'h0 ||
        line_done !== 1'b0 || line_num !== 11'd0) begin
      n_miss++;
      $display("FAIL reset_outputs we=%b addr=%h din=%h done=%b num=%0d, expected all 0",
               ram_we, ram_addr, ram_din, line_done, line_num);
    end
    check_cnts("reset", 16'd0, 16'd0);
  endtask

  task automatic test_full_line();
    done_q.push_back(11'd5);
    send_pkt(11'd5, 1'b0, 640);
    send_pkt(11'd5, 1'b1, 640);
    check_drained("full_line");
    check_cnts("full_line", 16'd0, 16'd0);
  endtask

  task automatic test_short();
    send_pkt(11'd6, 1'b0, 600);
    check_drained("short");
    check_cnts("short", 16'd1, 16'd0);
    send_pkt(11'd6, 1'b1, 0);
    check_cnts("zero_word", 16'd2, 16'd0);
  endtask

  task automatic test_drop();
    send_pkt(11'd7, 1'b0, 640);
    check_cnts("drop_first", 16'd2, 16'd0);
    done_q.push_back(11'd8);
    send_pkt(11'd8, 1'b0, 640);
    check_cnts("drop", 16'd2, 16'd1);
    send_pkt(11'd8, 1'b1, 640);
    check_drained("drop");
    check_cnts("drop_done", 16'd2, 16'd1);
  endtask

  task automatic test_overlong();
    send_pkt(11'd9, 1'b0, 700);
    check_cnts("overlong", 16'd2, 16'd1);
    done_q.push_back(11'd9);
    send_pkt(11'd9, 1'b1, 640);
    check_drained("overlong");
  endtask

  task automatic test_reset_mid_packet();
    send_pkt(11'd10, 1'b0, 640);
    packet_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 100; i++) drive_word(11'd11, 1'b1, 1'b1, 10'(i));
    sys_rst = 1'b1;
    drive_word(11'd11, 1'b1, 1'b0, 10'd0);
    drive_word(11'd11, 1'b1, 1'b0, 10'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 200; i++) drive_word(11'd11, 1'b1, 1'b0, 10'd0);
    recv_en   = 1'b0;
    packet_en = 1'b0;
    repeat (14) tick();
    check_drained("rst_mid");
    check_cnts("rst_mid", 16'd0, 16'd0);
    done_q.push_back(11'd12);
    send_pkt(11'd12, 1'b0, 640);
    send_pkt(11'd12, 1'b1, 640);
    check_drained("after_rst");
    check_cnts("after_rst", 16'd0, 16'd0);
  endtask

  task automatic test_saturation();
    force dut.u_short_cnt.cnt_q = 16'hFFFF;
    tick();
    release dut.u_short_cnt.cnt_q;
    tick();
    check_cnts("sat_preload", 16'hFFFF, 16'd0);
    send_pkt(11'd13, 1'b0, 50);
    check_drained("sat");
    check_cnts("sat", 16'hFFFF, 16'd0);
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short();
    test_drop();
    test_overlong();
    test_reset_mid_packet();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
